cp0_regfile: RTL and testbench

//  Coprocessor-0 register file: write-back consumer of the MEM/WB cp0 write triple (we/addr/data).

---
 rtl/cp0_regfile_pkg.sv | 28 ++
 rtl/cp0_regfile.sv | 134 +++++++++++++
 tb/tb_cp0_regfile.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_pkg.sv
// +--------------------------------------------------------------------------+
// | cp0_regfile_pkg : shared CP0 register numbers, bus types and masks       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package cp0_regfile_pkg;

    localparam int          REG_BUS_W    = 32;
    typedef logic [REG_BUS_W-1:0] reg_bus_t;

    localparam reg_bus_t    ZERO_WORD    = 32'h0000_0000;
    localparam logic        WRITE_ENABLE = 1'b1;

    localparam logic [4:0]  CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0]  CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0]  CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0]  CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0]  CP0_REG_EPC     = 5'd14;
    localparam logic [4:0]  CP0_REG_PRID    = 5'd15;
    localparam logic [4:0]  CP0_REG_CONFIG  = 5'd16;

    // Software-writable Cause bits: IV[23], WP[22], IP[9:8]
    localparam reg_bus_t    CAUSE_WMASK  = 32'h00C0_0300;

endpackage : cp0_regfile_pkg

`default_nettype wire

// File: rtl/cp0_regfile.sv
// +--------------------------------------------------------------------------+
// | cp0_regfile : CP0 register file with Count/Compare timer interrupt       |
// | Optional feature macro: CP0_TIMER_INT_EN (timer match + cause[15] OR)     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
    parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    reg_bus_t count;
    reg_bus_t compare;
    reg_bus_t status;
    reg_bus_t cause;
    reg_bus_t epc;
    reg_bus_t cause_next;
    logic     timer_int;
    logic     ip7;

    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    assign wr_count   = (we_i == WRITE_ENABLE) && (waddr_i == CP0_REG_COUNT);
    assign wr_compare = (we_i == WRITE_ENABLE) && (waddr_i == CP0_REG_COMPARE);
    assign wr_status  = (we_i == WRITE_ENABLE) && (waddr_i == CP0_REG_STATUS);
    assign wr_cause   = (we_i == WRITE_ENABLE) && (waddr_i == CP0_REG_CAUSE);
    assign wr_epc     = (we_i == WRITE_ENABLE) && (waddr_i == CP0_REG_EPC);

`ifdef CP0_TIMER_INT_EN
    logic timer_match;

    // Match uses the pre-update count; a Compare write always clears the request.
    assign timer_match = (compare != ZERO_WORD) && (count == compare);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_int <= 1'b0;
        end else if (wr_compare) begin
            timer_int <= 1'b0;
        end else if (timer_match) begin
            timer_int <= 1'b1;
        end
    end

    assign ip7 = int_i[5] | timer_int;
`else
    assign timer_int = 1'b0;
    assign ip7       = int_i[5];
`endif

    always_comb begin
        cause_next = cause;
        if (wr_cause) begin
            cause_next = (cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        end
        cause_next[15:10] = {ip7, int_i[4:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= ZERO_WORD;
            compare <= ZERO_WORD;
            status  <= STATUS_RESET;
            cause   <= ZERO_WORD;
            epc     <= ZERO_WORD;
        end else begin
            count <= wr_count ? data_i : count + 32'd1;
            cause <= cause_next;
            if (wr_compare) begin
                compare <= data_i;
            end
            if (wr_status) begin
                status <= data_i;
            end
            if (wr_epc) begin
                epc <= data_i;
            end
        end
    end

    // Registered state only: a write shows up here the cycle after we_i.
    always_comb begin
        data_o = ZERO_WORD;
        if (!rst) begin
            case (raddr_i)
                CP0_REG_COUNT:   data_o = count;
                CP0_REG_COMPARE: data_o = compare;
                CP0_REG_STATUS:  data_o = status;
                CP0_REG_CAUSE:   data_o = cause;
                CP0_REG_EPC:     data_o = epc;
                CP0_REG_PRID:    data_o = PRID_VALUE;
                CP0_REG_CONFIG:  data_o = CONFIG_VALUE;
                default:         data_o = ZERO_WORD;
            endcase
        end
    end

    assign count_o     = count;
    assign compare_o   = compare;
    assign status_o    = status;
    assign cause_o     = cause;
    assign epc_o       = epc;
    assign config_o    = CONFIG_VALUE;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = timer_int;

endmodule : cp0_regfile

`default_nettype wire

// File: tb/tb_cp0_regfile.sv
// +--------------------------------------------------------------------------+
// | tb_cp0_regfile : scoreboard bench for cp0_regfile                        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cp0_regfile;

`ifdef CP0_TIMER_INT_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    cp0_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .data_i      (data_i),
        .raddr_i     (raddr_i),
        .int_i       (int_i),
        .data_o      (data_o),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .config_o    (config_o),
        .prid_o      (prid_o),
        .timer_int_o (timer_int_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        timer;
    } snap_t;

    snap_t exp_q[$];
    snap_t s;

    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;
    int total = 0;
    int bad   = 0;

    // Drive one cycle of stimulus, advance the reference model and queue the expectation.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [5:0] irq);
        logic        match;
        logic [31:0] n_cause;
        logic [31:0] mask;
        mask     = 32'h00C0_0300;
        we_i     = we;
        waddr_i  = wa;
        data_i   = wd;
        int_i    = irq;
        match    = TIMER_EN && (m_compare != 32'd0) && (m_count == m_compare);
        n_cause  = m_cause;
        if (we && wa == 5'd13) n_cause = (m_cause & ~mask) | (wd & mask);
        n_cause[15:10] = irq;
        if (TIMER_EN) n_cause[15] = irq[5] | m_timer;
        m_cause  = n_cause;
        if (TIMER_EN) m_timer = (we && wa == 5'd11) ? 1'b0 : (m_timer | match);
        m_count   = (we && wa == 5'd9)  ? wd : m_count + 32'd1;
        m_compare = (we && wa == 5'd11) ? wd : m_compare;
        m_status  = (we && wa == 5'd12) ? wd : m_status;
        m_epc     = (we && wa == 5'd14) ? wd : m_epc;
        exp_q.push_back('{m_count, m_compare, m_status, m_cause, m_epc, m_timer});
        @(posedge clk);
        #1;
        we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = 5'd12; int_i = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (data_o !== 32'd0) begin
            bad++; $display("FAIL reset_data_o got=%h want=%h", data_o, 32'd0);
        end
        total++;
        if (count_o !== 32'd0 || compare_o !== 32'd0 || cause_o !== 32'd0 || epc_o !== 32'd0) begin
            bad++; $display("FAIL reset_zero_regs got=%h/%h/%h/%h want=0", count_o, compare_o, cause_o, epc_o);
        end
        total++;
        if (status_o !== 32'h1000_0000 || timer_int_o !== 1'b0) begin
            bad++; $display("FAIL reset_status got=%h/%b want=10000000/0", status_o, timer_int_o);
        end
        m_count = 0; m_compare = 0; m_status = 32'h1000_0000; m_cause = 0; m_epc = 0; m_timer = 0;
        rst = 1'b0;
    endtask

    task automatic test_idle_count();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 6'd0);
            s = exp_q.pop_front();
            total++;
            if (count_o !== s.count) begin
                bad++; $display("FAIL idle_count[%0d] got=%h want=%h", i, count_o, s.count);
            end
        end
        total++;
        if (count_o !== 32'd5 || status_o !== 32'h1000_0000 || prid_o !== 32'h0048_0102
            || config_o !== 32'h0000_8000 || timer_int_o !== 1'b0) begin
            bad++; $display("FAIL idle_summary got=%h/%h/%h/%h/%b want=5/10000000/00480102/00008000/0",
                            count_o, status_o, prid_o, config_o, timer_int_o);
        end
        raddr_i = 5'd9; #1;
        total++;
        if (data_o !== s.count) begin
            bad++; $display("FAIL read_count got=%h want=%h", data_o, s.count);
        end
    endtask

    task automatic test_timer();
        int rise_at = -1;
        cycle(1'b1, 5'd11, 32'h20, 6'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 5'd9, 32'h1E, 6'd0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 6'd0);
            s = exp_q.pop_front();
            total++;
            if (timer_int_o !== s.timer || count_o !== s.count || cause_o !== s.cause) begin
                bad++; $display("FAIL timer_step[%0d] got=%b/%h/%h want=%b/%h/%h",
                                i, timer_int_o, count_o, cause_o, s.timer, s.count, s.cause);
            end
            if (timer_int_o === 1'b1 && rise_at < 0) rise_at = i;
        end
        total++;
        if (timer_int_o !== TIMER_EN) begin
            bad++; $display("FAIL timer_sticky got=%b want=%b (rise_at=%0d)", timer_int_o, TIMER_EN, rise_at);
        end
        cycle(1'b1, 5'd11, 32'h40, 6'd0);
        s = exp_q.pop_front();
        total++;
        if (timer_int_o !== 1'b0 || compare_o !== 32'h40) begin
            bad++; $display("FAIL timer_clear got=%b/%h want=0/00000040", timer_int_o, compare_o);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 5'd11, 32'd0, 6'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 5'd9, 32'hFFFF_FFFF, 6'd0);
        s = exp_q.pop_front();
        total++;
        if (count_o !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_load got=%h want=ffffffff", count_o);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 6'd0);
            s = exp_q.pop_front();
            total++;
            if (count_o !== s.count || timer_int_o !== 1'b0) begin
                bad++; $display("FAIL wrap_step[%0d] got=%h/%b want=%h/0", i, count_o, timer_int_o, s.count);
            end
        end
    endtask

    task automatic test_cause();
        cycle(1'b1, 5'd13, 32'hFFFF_FFFF, 6'd0);
        s = exp_q.pop_front();
        total++;
        if (cause_o !== 32'h00C0_0300 || cause_o !== s.cause) begin
            bad++; $display("FAIL cause_write got=%h want=00c00300", cause_o);
        end
        cycle(1'b0, 5'd0, 32'd0, 6'b000101);
        s = exp_q.pop_front();
        total++;
        if (cause_o[15:10] !== 6'b000101 || cause_o !== s.cause) begin
            bad++; $display("FAIL cause_ip got=%h want=%h", cause_o, s.cause);
        end
        cycle(1'b0, 5'd0, 32'd0, 6'b100000);
        s = exp_q.pop_front();
        total++;
        if (cause_o !== s.cause) begin
            bad++; $display("FAIL cause_ip7 got=%h want=%h", cause_o, s.cause);
        end
    endtask

    task automatic test_ro_unmapped();
        cycle(1'b1, 5'd15, 32'd0, 6'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 5'd16, 32'd0, 6'd0);
        s = exp_q.pop_front();
        total++;
        if (prid_o !== 32'h0048_0102 || config_o !== 32'h0000_8000) begin
            bad++; $display("FAIL ro_regs got=%h/%h want=00480102/00008000", prid_o, config_o);
        end
        raddr_i = 5'd3; #1;
        total++;
        if (data_o !== 32'd0) begin
            bad++; $display("FAIL read_unmapped got=%h want=0", data_o);
        end
        raddr_i = 5'd15; #1;
        total++;
        if (data_o !== 32'h0048_0102) begin
            bad++; $display("FAIL read_prid got=%h want=00480102", data_o);
        end
        raddr_i = 5'd16; #1;
        total++;
        if (data_o !== 32'h0000_8000) begin
            bad++; $display("FAIL read_config got=%h want=00008000", data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_epc;
        old_epc = m_epc;
        raddr_i = 5'd14;
        cycle(1'b1, 5'd12, 32'hA5A5_0001, 6'd0);
        void'(exp_q.pop_front());
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hDEAD_BEEF; #1;
        total++;
        if (data_o !== old_epc) begin
            bad++; $display("FAIL no_bypass got=%h want=%h", data_o, old_epc);
        end
        cycle(1'b1, 5'd14, 32'hDEAD_BEEF, 6'd0);
        s = exp_q.pop_front();
        total++;
        if (data_o !== 32'hDEAD_BEEF || epc_o !== s.epc || status_o !== s.status) begin
            bad++; $display("FAIL write_read got=%h/%h/%h want=deadbeef/%h/%h", data_o, epc_o, status_o, s.epc, s.status);
        end
    endtask

    task automatic test_same_cycle();
        cycle(1'b1, 5'd11, 32'h100, 6'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 5'd9, 32'hFE, 6'd0);
        void'(exp_q.pop_front());
        cycle(1'b0, 5'd0, 32'd0, 6'd0);
        void'(exp_q.pop_front());
        cycle(1'b0, 5'd0, 32'd0, 6'd0);
        void'(exp_q.pop_front());
        total++;
        if (count_o !== 32'h100) begin
            bad++; $display("FAIL same_setup got=%h want=00000100", count_o);
        end
        cycle(1'b1, 5'd11, 32'h100, 6'd0);
        s = exp_q.pop_front();
        total++;
        if (timer_int_o !== 1'b0 || timer_int_o !== s.timer) begin
            bad++; $display("FAIL same_cycle_clear got=%b want=0", timer_int_o);
        end
        cycle(1'b0, 5'd0, 32'd0, 6'd0);
        s = exp_q.pop_front();
        total++;
        if (timer_int_o !== 1'b0) begin
            bad++; $display("FAIL same_cycle_after got=%b want=0", timer_int_o);
        end
    endtask

    task automatic test_mid_reset();
        cycle(1'b1, 5'd11, 32'h110, 6'b111111);
        void'(exp_q.pop_front());
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (timer_int_o !== 1'b0 || cause_o !== 32'd0 || count_o !== 32'd0 || data_o !== 32'd0) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%h/%h want=0/0/0/0", timer_int_o, cause_o, count_o, data_o);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_count();
        test_timer();
        test_wrap();
        test_cause();
        test_ro_unmapped();
        test_back_to_back();
        test_same_cycle();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_cp0_regfile

`default_nettype wire
